ex_mul_seq: RTL and testbench
=============================

Name: ex_mul_seq

Overview:
- Iterative shift-add multiply sequencer for the execute stage.
- Computes an unsigned WIDTH x WIDTH product over WIDTH cycles by time-sharing the existing ALU adder. The block drives the ALU operands and opcode, and takes back the ALU sum and carry.
- Stalls the pipeline while it runs, then presents a 2*WIDTH-bit product.

Parameters:
- WIDTH, 16, operand width; the product is 2*WIDTH bits.
- ADD_OP, 4'b0100, ALU opcode driven on alu_op for an unsigned add.
- CNT_W, 5, iteration counter width; must be at least clog2(WIDTH)+1.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  request a multiply; accepted only in IDLE or DONE.
- flush  in  1  synchronous abort; return to IDLE, no done.
- op_a  in  WIDTH  multiplicand, sampled on accept.
- op_b  in  WIDTH  multiplier, sampled on accept.
- alu_A  out  WIDTH  ALU operand A, always equal to P_reg.
- alu_B  out  WIDTH  ALU operand B: M_reg if Q_reg[0]=1, else 0.
- alu_op  out  4  constant ADD_OP.
- alu_Cin  out  1  constant 0.
- alu_out  in  WIDTH  ALU sum, combinational from alu_A/alu_B.
- alu_cout  in  1  ALU carry out of the same add.
- busy  out  1  high in RUN.
- stall  out  1  busy OR (start accepted this cycle); combinational.
- done  out  1  one-cycle pulse in DONE.
- prod_hi  out  WIDTH  upper product half.
- prod_lo  out  WIDTH  lower product half.

Behaviour:
- Registers:
  - M_reg (multiplicand)
  - P_reg (partial high)
  - Q_reg (multiplier/low)
  - cnt
  - state ∈ {IDLE, RUN, DONE}
- Reset (rst_n=0, asynchronous):
  - state=IDLE; M_reg, P_reg, Q_reg, cnt all cleared.
  - Outputs: busy=0, done=0, stall=0, prod_hi=0, prod_lo=0.
  - Reset mid-RUN discards the operation; no done is produced.
- Accept condition: start=1 and state ∈ {IDLE, DONE} and flush=0. On accept:
  - M_reg<=op_a, Q_reg<=op_b, P_reg<=0, cnt<=0, state<=RUN.
- RUN, each cycle, one iteration:
  - {P_reg,Q_reg} <= {alu_cout, alu_out, Q_reg[WIDTH-1:1]}, i.e. the 2*WIDTH+1-bit value {cout,sum,Q} shifted right by 1.
  - cnt<=cnt+1.
  - When cnt==WIDTH-1, state<=DONE.
  - When Q_reg[0]=0, alu_B=0, so sum=P_reg and cout=0 (plain shift).
- DONE:
  - done=1 for exactly this cycle.
  - If start=1, re-accept (back-to-back) and go to RUN.
  - Otherwise go to IDLE.
- Product outputs:
  - prod_hi=P_reg, prod_lo=Q_reg.
  - Valid from the DONE cycle and held unchanged in IDLE until the next accept.
- Latency:
  - Accept at edge k; RUN occupies cycles k+1 .. k+WIDTH; DONE is cycle k+WIDTH+1.
  - For WIDTH=16, done is high 17 cycles after the start cycle.
- start while in RUN: ignored; does not restart and is not queued.
- flush=1:
  - In any state, next state is IDLE and done is not asserted.
  - P_reg/Q_reg keep their partial contents.
  - flush has priority over start in the same cycle.
- Stall:
  - stall=1 in the accept cycle and in all RUN cycles; 0 in DONE and IDLE.
  - The pipeline advances on the done cycle.
- Arithmetic:
  - Unsigned only. The full 2*WIDTH product is exact; there is no overflow.
  - alu_cout must come from the same add that produced alu_out.

Test Plan:
- Simple multiply with ALU model attached: op_a=3, op_b=5, start one cycle -> stall high 17 cycles, done pulse at cycle +17, prod_hi=0x0000, prod_lo=0x000F.
- Maximum operands: op_a=0xFFFF, op_b=0xFFFF -> prod_hi=0xFFFE, prod_lo=0x0001; carry path exercised.
- Zero and identity operands:
  - op_a=0x1234, op_b=0 -> product 0.
  - op_a=0, op_b=0xFFFF -> product 0.
  - op_a=0x8000, op_b=2 -> prod_hi=0x0001, prod_lo=0x0000.
- start during RUN and back-to-back:
  - start re-pulsed in RUN cycle 5 -> ignored; result still for the first operands.
  - start held in the DONE cycle with op_a=7, op_b=9 -> new RUN begins with no IDLE gap; second done gives prod_lo=0x003F.
- Aborts:
  - flush asserted in RUN cycle 8 -> IDLE next cycle, no done, busy=0.
  - start and flush together in IDLE -> not accepted.
- Reset mid-operation: rst_n pulled low mid-RUN (asynchronous, between edges) -> busy, stall, prod_* go to 0 immediately; after release the block idles until start.

Source files
------------

// File: rtl/ex_mul_seq.sv
// ----------------------------------------------------------------------------
// ex_mul_seq
//
// Iterative shift-add multiplier for the execute stage. It computes an
// unsigned WIDTH x WIDTH product in WIDTH cycles. It does this by borrowing
// the existing ALU adder: the block drives the ALU operands and opcode, then
// takes back the sum and carry from that same add.
//
// Ports
//   clk, rst_n        clock, asynchronous active-low reset
//   start, flush      multiply request / synchronous abort (flush wins)
//   op_a, op_b        multiplicand / multiplier, sampled on accept
//   alu_A, alu_B      ALU operands (partial high word, gated multiplicand)
//   alu_op, alu_Cin   constant unsigned-add opcode, carry-in tied low
//   alu_out, alu_cout ALU sum and carry of the add driven above
//   busy              high while iterating
//   stall             holds the pipeline: busy or a request accepted now
//   done              one-cycle pulse when the product is ready
//   prod_hi, prod_lo  product halves, held until the next accept
//   dbg_state         current FSM state, for observation only
//
// Handshake: start is a request qualified by the FSM state. It is accepted
// in the same cycle it is seen, but only if the FSM is in IDLE or DONE and
// flush is low. A start that arrives while busy is dropped; it is not queued.
// The upstream pipeline must hold while stall=1. It advances on the done
// cycle unless a new request is accepted in that same cycle.
// ----------------------------------------------------------------------------
module ex_mul_seq #(
    parameter int          WIDTH  = 16,
    parameter logic [3:0]  ADD_OP = 4'b0100,
    // Must be at least clog2(WIDTH)+1 so the counter can reach WIDTH-1.
    parameter int          CNT_W  = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             flush,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    output logic [WIDTH-1:0] alu_A,
    output logic [WIDTH-1:0] alu_B,
    output logic [3:0]       alu_op,
    output logic             alu_Cin,
    input  logic [WIDTH-1:0] alu_out,
    input  logic             alu_cout,
    output logic             busy,
    output logic             stall,
    output logic             done,
    output logic [WIDTH-1:0] prod_hi,
    output logic [WIDTH-1:0] prod_lo,
    output logic [1:0]       dbg_state
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    logic [1:0]       state_q, state_d;
    logic [WIDTH-1:0] m_q, m_d;
    logic [WIDTH-1:0] p_q, p_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             accept;

    assign accept = start && !flush && ((state_q == S_IDLE) || (state_q == S_DONE));

    // Only add the multiplicand when the current multiplier bit is set.
    // Otherwise the ALU just passes P through with cout=0, so the iteration
    // becomes a plain shift.
    assign alu_A   = p_q;
    assign alu_B   = q_q[0] ? m_q : '0;
    assign alu_op  = ADD_OP;
    assign alu_Cin = 1'b0;

    assign busy      = (state_q == S_RUN);
    assign done      = (state_q == S_DONE);
    assign stall     = busy || accept;
    assign prod_hi   = p_q;
    assign prod_lo   = q_q;
    assign dbg_state = state_q;

    always_comb begin
        state_d = state_q;
        m_d     = m_q;
        p_d     = p_q;
        q_d     = q_q;
        cnt_d   = cnt_q;

        if (flush) begin
            // The partial P/Q contents are left as they are. Only the
            // sequencing is abandoned.
            state_d = S_IDLE;
        end else if (accept) begin
            m_d     = op_a;
            q_d     = op_b;
            p_d     = '0;
            cnt_d   = '0;
            state_d = S_RUN;
        end else begin
            case (state_q)
                S_RUN: begin
                    // {cout, sum, Q} shifted right by one. The bit that
                    // drops out of the sum becomes the new top bit of Q.
                    p_d   = {alu_cout, alu_out[WIDTH-1:1]};
                    q_d   = {alu_out[0], q_q[WIDTH-1:1]};
                    cnt_d = cnt_q + CNT_W'(1);
                    if (cnt_q == LAST_CNT) begin
                        state_d = S_DONE;
                    end
                end
                S_DONE: begin
                    state_d = S_IDLE;
                end
                default: begin
                    // IDLE holds. The unused encoding recovers to IDLE.
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            m_q     <= '0;
            p_q     <= '0;
            q_q     <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            m_q     <= m_d;
            p_q     <= p_d;
            q_q     <= q_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule

// File: tb/tb_ex_mul_seq.sv
// ----------------------------------------------------------------------------
// tb_ex_mul_seq
//
// Bench for ex_mul_seq with a behavioural ALU attached. A cycle-level
// reference model tracks the expected behaviour: the number of run cycles
// left, when done should pulse, and the expected products (arithmetic a*b,
// held in a queue). Every cycle, the bench compares the DUT outputs against
// that model.
// ----------------------------------------------------------------------------
module tb_ex_mul_seq;

    localparam int W = 16;

    logic           clk;
    logic           rst_n;
    logic           start;
    logic           flush;
    logic [W-1:0]   op_a;
    logic [W-1:0]   op_b;
    logic [W-1:0]   alu_A;
    logic [W-1:0]   alu_B;
    logic [3:0]     alu_op;
    logic           alu_Cin;
    logic [W-1:0]   alu_out;
    logic           alu_cout;
    logic           busy;
    logic           stall;
    logic           done;
    logic [W-1:0]   prod_hi;
    logic [W-1:0]   prod_lo;
    logic [1:0]     dbg_state;

    ex_mul_seq #(
        .WIDTH  (W),
        .ADD_OP (4'b0100),
        .CNT_W  (5)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .flush     (flush),
        .op_a      (op_a),
        .op_b      (op_b),
        .alu_A     (alu_A),
        .alu_B     (alu_B),
        .alu_op    (alu_op),
        .alu_Cin   (alu_Cin),
        .alu_out   (alu_out),
        .alu_cout  (alu_cout),
        .busy      (busy),
        .stall     (stall),
        .done      (done),
        .prod_hi   (prod_hi),
        .prod_lo   (prod_lo),
        .dbg_state (dbg_state)
    );

    // Behavioural ALU: unsigned add when the opcode says so.
    logic [W:0] alu_sum;
    assign alu_sum  = (alu_op == 4'b0100) ? ({1'b0, alu_A} + {1'b0, alu_B} + {{W{1'b0}}, alu_Cin}) : '0;
    assign alu_out  = alu_sum[W-1:0];
    assign alu_cout = alu_sum[W];

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- scoreboard / model state ----------------
    int             n_checks;
    int             n_errors;
    logic [31:0]    exp_q[$];
    int             run_left;     // RUN cycles still to come, 0 when not running
    bit             done_now;     // a done pulse is expected this cycle
    bit             prod_known;   // product outputs have a defined expected value
    logic [31:0]    last_prod;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
        end
    endtask

    // Compare this cycle's outputs with the model, then advance the model
    // across the coming rising edge.
    task automatic model_cycle();
        bit          acc;
        logic [31:0] exp;
        acc = start && !flush && (run_left == 0);
        check_eq("busy",    32'(busy),    32'(run_left > 0));
        check_eq("stall",   32'(stall),   32'((run_left > 0) || acc));
        check_eq("done",    32'(done),    32'(done_now));
        check_eq("alu_op",  32'(alu_op),  32'h4);
        check_eq("alu_cin", 32'(alu_Cin), 32'h0);
        if (done_now) begin
            exp = exp_q.pop_front();
            check_eq("prod_done", {prod_hi, prod_lo}, exp);
            last_prod  = exp;
            prod_known = 1'b1;
        end else if (run_left == 0 && prod_known) begin
            check_eq("prod_hold", {prod_hi, prod_lo}, last_prod);
        end

        if (flush) begin
            if (run_left > 0) begin
                exp_q.delete();
                prod_known = 1'b0;
            end
            run_left = 0;
            done_now = 1'b0;
        end else if (acc) begin
            exp_q.push_back({16'h0, op_a} * {16'h0, op_b});
            run_left   = W;
            done_now   = 1'b0;
            prod_known = 1'b0;
        end else if (run_left > 0) begin
            run_left--;
            done_now = (run_left == 0);
        end else begin
            done_now = 1'b0;
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic step(input logic s, input logic f, input logic [W-1:0] a, input logic [W-1:0] b);
        @(negedge clk);
        start = s;
        flush = f;
        op_a  = a;
        op_b  = b;
        #1;
        model_cycle();
    endtask

    // One isolated multiply. It also measures start-to-done latency directly.
    task automatic run_one(input logic [W-1:0] a, input logic [W-1:0] b);
        int lat;
        bit seen;
        seen = 1'b0;
        lat  = 0;
        step(1'b1, 1'b0, a, b);
        for (int i = 1; i <= 40 && !seen; i++) begin
            step(1'b0, 1'b0, 16'h0, 16'h0);
            if (done) begin
                seen = 1'b1;
                lat  = i;
            end
        end
        check_eq("latency", 32'(lat), 32'd17);
    endtask

    task automatic rand_operand(output logic [W-1:0] v);
        case ($urandom_range(0, 4))
            0:       v = 16'hFFFF;
            1:       v = 16'h0000;
            2:       v = 16'h0001;
            default: v = W'($urandom);
        endcase
    endtask

    // ---------------- main sequence ----------------
    initial begin
        logic [W-1:0] ra;
        logic [W-1:0] rb;
        n_checks   = 0;
        n_errors   = 0;
        run_left   = 0;
        done_now   = 1'b0;
        prod_known = 1'b1;
        last_prod  = '0;
        rst_n = 1'b0;
        start = 1'b0;
        flush = 1'b0;
        op_a  = '0;
        op_b  = '0;

        // Outputs while in reset.
        #2;
        check_eq("rst_busy",  32'(busy),  32'h0);
        check_eq("rst_stall", 32'(stall), 32'h0);
        check_eq("rst_done",  32'(done),  32'h0);
        check_eq("rst_prod",  {prod_hi, prod_lo}, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) step(1'b0, 1'b0, 16'h0, 16'h0);

        // Basic and corner operands.
        run_one(16'h0003, 16'h0005);
        run_one(16'hFFFF, 16'hFFFF);
        run_one(16'h1234, 16'h0000);
        run_one(16'h0000, 16'hFFFF);
        run_one(16'h8000, 16'h0002);
        repeat (2) step(1'b0, 1'b0, 16'h0, 16'h0);

        // start re-pulsed in RUN cycle 5 is ignored.
        step(1'b1, 1'b0, 16'd11, 16'd13);
        repeat (4) step(1'b0, 1'b0, 16'h0, 16'h0);
        step(1'b1, 1'b0, 16'd99, 16'd99);
        repeat (14) step(1'b0, 1'b0, 16'h0, 16'h0);

        // Back-to-back: start held in the DONE cycle.
        step(1'b1, 1'b0, 16'd2, 16'd3);
        repeat (16) step(1'b0, 1'b0, 16'h0, 16'h0);
        step(1'b1, 1'b0, 16'd7, 16'd9);
        repeat (18) step(1'b0, 1'b0, 16'h0, 16'h0);

        // flush in RUN cycle 8: no done afterwards.
        step(1'b1, 1'b0, 16'h00AB, 16'h00CD);
        repeat (7) step(1'b0, 1'b0, 16'h0, 16'h0);
        step(1'b0, 1'b1, 16'h0, 16'h0);
        repeat (20) step(1'b0, 1'b0, 16'h0, 16'h0);

        // start and flush together in IDLE: not accepted.
        step(1'b1, 1'b1, 16'd5, 16'd5);
        repeat (3) step(1'b0, 1'b0, 16'h0, 16'h0);
        run_one(16'd100, 16'd200);

        // Asynchronous reset mid-RUN, asserted between edges.
        step(1'b1, 1'b0, 16'hBEEF, 16'h1357);
        repeat (6) step(1'b0, 1'b0, 16'h0, 16'h0);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("arst_busy",  32'(busy),  32'h0);
        check_eq("arst_stall", 32'(stall), 32'h0);
        check_eq("arst_done",  32'(done),  32'h0);
        check_eq("arst_prod",  {prod_hi, prod_lo}, 32'h0);
        run_left   = 0;
        done_now   = 1'b0;
        exp_q.delete();
        prod_known = 1'b1;
        last_prod  = '0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (25) step(1'b0, 1'b0, 16'h0, 16'h0);

        // Randomized traffic.
        for (int i = 0; i < 1500; i++) begin
            rand_operand(ra);
            rand_operand(rb);
            step(($urandom_range(0, 7) == 0), ($urandom_range(0, 59) == 0), ra, rb);
        end
        repeat (20) step(1'b0, 1'b0, 16'h0, 16'h0);
        check_eq("queue_empty", 32'(exp_q.size()), 32'h0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    // Global time bound so the run always ends by itself.
    initial begin
        #2000000;
        $display("FAIL timeout got=0x%08h exp=0x%08h", 32'h1, 32'h0);
        $fatal(1, "timeout");
    end

endmodule
